ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//  Instruction prefetch queue between the instruction memory (im) and the
//  instruction register (ir) of the SISC datapath.
//  - Drives the im read address and buffers fetched words in a small FIFO.
//  - Hands instructions to ir over a valid/ready handshake; ready = ir_load.
//  - Discards buffered words on a control-flow redirect (branch taken) and
//    restarts fetch at the redirect target.
// PARAMETERS
//  DEPTH  4   queue entries; power of two, 2..16
//  AW     16  instruction address width (word address, matches pc_out)
//  DW     32  instruction width
// PORTS
//  clk            in   1             system clock, rising edge
//  rst_f          in   1             synchronous, active-low reset
//  imem_addr      out  AW            fetch address to im read_addr
//  imem_data      in   DW            im read_data; combinational, same cycle
//  flush          in   1             redirect request from ctrl
//  redirect_addr  in   AW            new fetch address (br_addr)
//  instr_out      out  DW            head instruction, to ir read_data
//  instr_pc       out  AW            address of head instruction
//  instr_valid    out  1             head entry holds a valid instruction
//  instr_ready    in   1             consumer accepts head this cycle
//  count          out  $clog2(DEPTH+1) occupied entries
// BEHAVIOUR
//  - Reset (rst_f=0 at a clk edge): fetch_pc=0, head=tail=0, count=0,
//    instr_valid=0, instr_out=0, instr_pc=0. Overrides every other input,
//    including a reset in the middle of a fetch or flush.
//  - imem_addr = fetch_pc, driven from a register.
//  - pop = instr_valid & instr_ready.
//  - push = !flush & (count<DEPTH | pop).
//  - On push: entry[tail] <= {fetch_pc, imem_data}; tail++; fetch_pc++.
//  - On pop: head++.
//  - count updates by +push-pop.
//  - Full queue with simultaneous pop: push is accepted and count stays DEPTH.
//  - Full queue without pop: no push; fetch_pc holds.
//  - fetch_pc arithmetic is modulo 2^AW: 16'hFFFF + 1 = 16'h0000.
//  - Pointers wrap modulo DEPTH.
//  - Flush has priority over push and pop. In the flush cycle:
//    head=tail=0, count=0, fetch_pc <= redirect_addr, no push.
//    A pop asserted in the flush cycle is dropped.
//  - Flush latency: redirect_addr is fetched in cycle N+1 and becomes the head
//    (instr_valid=1) in cycle N+2.
//  - Back-to-back flushes: the last one wins.
//  - Empty queue: instr_valid=0 and instr_out=0. instr_ready is ignored.
//  - Outputs are combinational from entry[head]. Only instr_ready may be
//    sampled by the consumer; no outputs depend combinationally on it.
//  - No parity or error reporting; im is assumed to always return data.
// CONFIGURATION
//  IFQ_BYPASS_EN
//   - Defined: when count==0 and !flush, the block presents imem_data on
//     instr_out and fetch_pc on instr_pc, with instr_valid=1 in the same cycle
//     (zero-latency fetch).
//     - If instr_ready=1 that cycle, the word is consumed and is not written:
//       fetch_pc++, count stays 0.
//     - Otherwise the word is pushed normally.
//     - Flush-to-valid latency becomes 1 cycle.
//   - Undefined: an empty queue always gives instr_valid=0, and every
//     instruction passes through the FIFO with a minimum latency of 1 cycle.
// TESTING
//  1 Reset: hold rst_f=0 for 2 clk; release. Required:
//    - imem_addr=0 in the first cycle.
//    - Words at 0,1,2,3 enter the queue; count reaches 4.
//    - instr_valid rises 1 cycle after release with instr_pc=0.
//  2 Back-pressure: instr_ready=0 for 10 cycles. Required:
//    - count=DEPTH=4 and imem_addr stalls at 4.
//    - When instr_ready=1 steadily, instructions come out in order 0..N,
//      one per cycle, with count held at 4.
//  3 Flush: with queue holding 5..8, flush=1 and redirect_addr=16'h0040 for
//    1 cycle. Required:
//    - Next cycle count=0 and imem_addr=16'h0040.
//    - 2 cycles after flush, instr_pc=16'h0040 (1 cycle with IFQ_BYPASS_EN).
//    - Words 5..8 never appear on the output.
//  4 Wrap-around: redirect_addr=16'hFFFE, instr_ready=1. Required:
//    instr_pc sequence FFFE, FFFF, 0000, 0001.
//  5 Flush and pop in the same cycle, with the queue full. Required:
//    - The pop is dropped and count=0 next cycle.
//    - The next instruction delivered is at redirect_addr.
//  6 Reset mid-stream: rst_f=0 for 1 cycle while count=3 and flush=1.
//    Required: count=0, imem_addr=0, instr_valid=0 the next cycle.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue between im and ir with redirect flush.
// Optional zero-latency bypass of an empty queue: define IFQ_BYPASS_EN.
module ifetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_f,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_data,
    input  logic          flush,
    input  logic [AW-1:0] redirect_addr,
    output logic [DW-1:0] instr_out,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] pc_mem_q   [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];

    logic fifo_valid;
    logic pop;
    logic push;
    logic byp_take;

    always_comb begin
        fifo_valid = (count_q != '0);
        pop        = fifo_valid & instr_ready & ~flush;
        byp_take   = 1'b0;
        instr_valid = fifo_valid;
        instr_out   = fifo_valid ? data_mem_q[head_q] : '0;
        instr_pc    = fifo_valid ? pc_mem_q[head_q] : '0;
`ifdef IFQ_BYPASS_EN
        // Empty queue forwards the word being fetched this cycle.
        if (!fifo_valid && !flush) begin
            instr_valid = 1'b1;
            instr_out   = imem_data;
            instr_pc    = fetch_pc_q;
            byp_take    = instr_ready;
        end
`endif
        push = ~flush & ((count_q < FULL) | pop) & ~byp_take;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (flush) begin
            fetch_pc_d = redirect_addr;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (push || byp_take) fetch_pc_d = fetch_pc_q + 1'b1;
            if (push) tail_d = tail_q + 1'b1;
            if (pop) head_d = head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            fetch_pc_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: outputs are gated by count.
    always_ff @(posedge clk) begin
        if (rst_f && push) begin
            pc_mem_q[tail_q]   <= fetch_pc_q;
            data_mem_q[tail_q] <= imem_data;
        end
    end

    assign imem_addr = fetch_pc_q;
    assign count     = count_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (default build, bypass disabled).
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst_f;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic        flush;
    logic [15:0] redirect_addr;
    logic [31:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory model: word at address a is {~a, a}.
    assign imem_data = {~imem_addr, imem_addr};

    ifetch_queue dut (
        .clk(clk), .rst_f(rst_f),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .flush(flush), .redirect_addr(redirect_addr),
        .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .count(count)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input logic [15:0] a);
        return {~a, a};
    endfunction

    initial begin
        rst_f = 1'b0;
        flush = 1'b0;
        redirect_addr = '0;
        instr_ready = 1'b0;
        step();
        step();
        check("rst_count", count, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_out", instr_out, 0);
        check("rst_pc", instr_pc, 0);

        rst_f = 1'b1;
        #1;
        check("first_addr", imem_addr, 0);
        step();
        check("rise_valid", instr_valid, 1);
        check("rise_pc", instr_pc, 0);
        check("rise_out", instr_out, word(16'h0000));
        check("rise_count", count, 1);
        for (int i = 0; i < 9; i++) step();
        check("bp_count", count, 4);
        check("bp_addr", imem_addr, 4);
        check("bp_head", instr_pc, 0);

        instr_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("stream_pc", instr_pc, 64'(k));
            check("stream_out", instr_out, word(16'(k)));
            check("stream_count", count, 4);
        end
        check("stream_addr", imem_addr, 9);

        instr_ready = 1'b0;
        flush = 1'b1;
        redirect_addr = 16'h0040;
        step();
        flush = 1'b0;
        instr_ready = 1'b1;
        check("fl_count", count, 0);
        check("fl_addr", imem_addr, 16'h0040);
        check("fl_valid", instr_valid, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("fl_pc", instr_pc, 64'(16'h0040 + k));
            check("fl_valid2", instr_valid, 1);
        end

        flush = 1'b1;
        redirect_addr = 16'hFFFE;
        step();
        flush = 1'b0;
        step();
        check("wrap_pc0", instr_pc, 16'hFFFE);
        step();
        check("wrap_pc1", instr_pc, 16'hFFFF);
        step();
        check("wrap_pc2", instr_pc, 16'h0000);
        check("wrap_out2", instr_out, word(16'h0000));
        step();
        check("wrap_pc3", instr_pc, 16'h0001);

        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("full_count", count, 4);
        instr_ready = 1'b1;
        flush = 1'b1;
        redirect_addr = 16'h0100;
        step();
        flush = 1'b0;
        check("fp_count", count, 0);
        check("fp_addr", imem_addr, 16'h0100);
        step();
        check("fp_pc", instr_pc, 16'h0100);
        check("fp_valid", instr_valid, 1);

        instr_ready = 1'b0;
        step();
        step();
        check("mid_count3", count, 3);
        rst_f = 1'b0;
        flush = 1'b1;
        redirect_addr = 16'h0055;
        step();
        check("mid_count", count, 0);
        check("mid_addr", imem_addr, 0);
        check("mid_valid", instr_valid, 0);
        rst_f = 1'b1;
        flush = 1'b0;
        step();
        check("mid_pc", instr_pc, 0);
        check("mid_valid2", instr_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
